lru_array: RTL
==============

LRU_ARRAY -- requirements
Module: lru_array

Interface
REQ-001 SHALL have parameter WAYS, default 4, number of ways per set; power of two, 2..8.
REQ-002 SHALL have parameter SETS, default 8, number of sets tracked; power of two, 2..256.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ready  output  1  high once every set holds a valid order.
REQ-006 SHALL have port touch  input  1  hit/fill strobe; marks touch_way as MRU in touch_set.
REQ-007 SHALL have port touch_set  input  log2(SETS)  set index for touch.
REQ-008 SHALL have port touch_way  input  log2(WAYS)  way index for touch.
REQ-009 SHALL have port inval  input  1  invalidate strobe; demotes inval_way to LRU in inval_set.
REQ-010 SHALL have port inval_set  input  log2(SETS)  set index for inval.
REQ-011 SHALL have port inval_way  input  log2(WAYS)  way index for inval.
REQ-012 SHALL have port query_set  input  log2(SETS)  set whose victim and MRU are reported.
REQ-013 SHALL have port victim  output  log2(WAYS)  LRU way of query_set, combinational from stored state.
REQ-014 SHALL have port mru  output  log2(WAYS)  MRU way of query_set, combinational from stored state.
REQ-015 SHALL have port repair  output  1  one-cycle pulse when a corrupt set order is rewritten.

Function
REQ-016 SHALL store per set an ordered list of WAYS way indices, position 0 = MRU, position WAYS-1 = LRU.
REQ-017 SHALL define default order as position i holding way WAYS-1-i (LRU = way 0, MRU = way WAYS-1).
REQ-018 SHALL, on touch with way at position p: shift positions 0..p-1 down one, place way at 0; update visible the cycle after the strobe.
REQ-019 SHALL leave the order unchanged when touch targets the current MRU way.
REQ-020 SHALL, on inval with way at position p: shift positions p+1..WAYS-1 up one, place way at WAYS-1.
REQ-021 SHALL, for touch and inval in the same cycle to the same set, apply touch first then inval to the result, as one write.
REQ-022 SHALL apply touch and inval to different sets independently in the same cycle.
REQ-023 SHALL ignore touch and inval while ready is low.
REQ-024 SHALL drive victim = 0 and mru = WAYS-1 while ready is low.
REQ-025 SHALL have victim/mru reflect a same-cycle touch to query_set only from the next cycle (no bypass).

Reset
REQ-026 SHALL, while reset is high, hold ready = 0, init counter = 0, repair = 0.
REQ-027 SHALL, each cycle after reset deasserts with ready low, write default order into set[counter] and increment counter.
REQ-028 SHALL set ready = 1 on the edge that writes set SETS-1, i.e. SETS rising edges after reset deasserts.
REQ-029 SHALL restart initialisation from set 0 if reset reasserts mid-initialisation.

Configuration
REQ-030 SHALL honour macro LRU_SELF_REPAIR_EN.
REQ-031 With LRU_SELF_REPAIR_EN defined: on touch or inval to a set whose stored order is not a permutation of 0..WAYS-1, SHALL write default order instead of the requested update and pulse repair for one cycle.
REQ-032 Without LRU_SELF_REPAIR_EN: no permutation check; repair tied 0; updates applied as in REQ-018..REQ-021.

Verification (WAYS=4, SETS=8)
REQ-033 Reset 1 cycle then release -> ready low for 7 edges, high after 8th; any query_set gives victim 0, mru 3.
REQ-034 Set 2: touch way 0 -> victim 1, mru 0; then touch 1, 2, 3 -> victim 0, mru 3.
REQ-035 Fresh set 4: touch way 3 -> order unchanged, victim 0, mru 3.
REQ-036 Fresh set 5: inval way 3 -> order 2,1,0,3; victim 3, mru 2.
REQ-037 Fresh set 6: touch way 0 and inval way 0 same cycle -> order 3,2,1,0; victim 0, mru 3.
REQ-038 Reset reasserted at init edge 4, touch issued during init -> ready rises 8 edges after release; touched set still default.

Source files
------------

// File: rtl/lru_array.sv
`default_nettype none
// ============================================================================
// Module   : lru_array
// Purpose  : Per-set true-LRU ordering for a set-associative structure.
//            Each set keeps an ordered list of way indices (position 0 =
//            MRU, position WAYS-1 = LRU). A touch promotes a way to MRU; an
//            invalidate demotes a way to LRU. After reset every set is
//            initialised to the default order, one set per cycle, and
//            ready rises once all sets hold a valid order.
// Ports    : clk        - single clock, rising edge
//            reset      - synchronous, active-high
//            ready      - all sets initialised; updates accepted
//            touch      - promote touch_way to MRU in touch_set
//            touch_set  - set index for touch
//            touch_way  - way index for touch
//            inval      - demote inval_way to LRU in inval_set
//            inval_set  - set index for inval
//            inval_way  - way index for inval
//            query_set  - set whose victim / mru are reported
//            victim     - LRU way of query_set (from stored state)
//            mru        - MRU way of query_set (from stored state)
//            repair     - one-cycle pulse when a corrupt order is rewritten
// Config   : define LRU_SELF_REPAIR_EN to enable the permutation check that
//            rewrites a corrupt set order with the default order.
// Revision : 1.0 - initial release
// ============================================================================
module lru_array #(
    parameter int WAYS = 4,
    parameter int SETS = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic                      ready,
    input  logic                      touch,
    input  logic [$clog2(SETS)-1:0]   touch_set,
    input  logic [$clog2(WAYS)-1:0]   touch_way,
    input  logic                      inval,
    input  logic [$clog2(SETS)-1:0]   inval_set,
    input  logic [$clog2(WAYS)-1:0]   inval_way,
    input  logic [$clog2(SETS)-1:0]   query_set,
    output logic [$clog2(WAYS)-1:0]   victim,
    output logic [$clog2(WAYS)-1:0]   mru,
    output logic                      repair
);

    localparam int c_way_w = $clog2(WAYS);
    localparam int c_set_w = $clog2(SETS);

    typedef logic [WAYS-1:0][c_way_w-1:0] order_t;

    // Position of way w in order o. A corrupt order may lack w entirely;
    // the LRU position is then used so the result is still well defined.
    function automatic int f_pos(input order_t o, input logic [c_way_w-1:0] w);
        int p;
        p = WAYS - 1;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (o[i] == w) p = i;
        end
        return p;
    endfunction

    // Promote w to position 0; entries above its old slot slide down one.
    function automatic order_t f_touch(input order_t o, input logic [c_way_w-1:0] w);
        order_t n;
        int     p;
        p = f_pos(o, w);
        for (int i = 0; i < WAYS; i++) begin
            if (i == 0)      n[i] = w;
            else if (i <= p) n[i] = o[i-1];
            else             n[i] = o[i];
        end
        return n;
    endfunction

    // Demote w to position WAYS-1; entries below its old slot slide up one.
    function automatic order_t f_inval(input order_t o, input logic [c_way_w-1:0] w);
        order_t n;
        int     p;
        p = f_pos(o, w);
        for (int i = 0; i < WAYS; i++) begin
            if (i < p)              n[i] = o[i];
            else if (i == WAYS - 1) n[i] = w;
            else                    n[i] = o[i+1];
        end
        return n;
    endfunction

    // True when every way index 0..WAYS-1 appears somewhere in the order.
    function automatic logic f_is_perm(input order_t o);
        logic ok;
        logic found;
        ok = 1'b1;
        for (int v = 0; v < WAYS; v++) begin
            found = 1'b0;
            for (int i = 0; i < WAYS; i++) begin
                if (o[i] == c_way_w'(v)) found = 1'b1;
            end
            if (!found) ok = 1'b0;
        end
        return ok;
    endfunction

    order_t               r_order [SETS];
    logic                 r_ready;
    logic [c_set_w-1:0]   r_cnt;
    logic                 r_repair;

    order_t               w_default;
    order_t               w_touch_old;
    order_t               w_inval_old;
    order_t               w_touch_new;
    order_t               w_inval_new;
    logic                 w_touch_en;
    logic                 w_inval_en;
    logic                 w_same;
    logic                 w_touch_bad;
    logic                 w_inval_bad;

    always_comb begin
        w_default = '0;
        for (int i = 0; i < WAYS; i++) begin
            w_default[i] = c_way_w'(WAYS - 1 - i);
        end
    end

    assign w_touch_en  = touch & r_ready;
    assign w_inval_en  = inval & r_ready;
    assign w_same      = w_touch_en & w_inval_en & (touch_set == inval_set);
    assign w_touch_old = r_order[touch_set];
    assign w_inval_old = r_order[inval_set];

`ifdef LRU_SELF_REPAIR_EN
    assign w_touch_bad = ~f_is_perm(w_touch_old);
    assign w_inval_bad = ~f_is_perm(w_inval_old);
`else
    assign w_touch_bad = 1'b0;
    assign w_inval_bad = 1'b0;
`endif

    // A same-set touch+inval collapses into one write on the touch path:
    // touch is applied first and the inval acts on that result.
    always_comb begin
        w_touch_new = f_touch(w_touch_old, touch_way);
        if (w_same) w_touch_new = f_inval(w_touch_new, inval_way);
        if (w_touch_bad) w_touch_new = w_default;
        w_inval_new = f_inval(w_inval_old, inval_way);
        if (w_inval_bad) w_inval_new = w_default;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ready  <= 1'b0;
            r_cnt    <= '0;
            r_repair <= 1'b0;
        end else begin
            r_repair <= (w_touch_en & w_touch_bad) | (w_inval_en & w_inval_bad);
            if (!r_ready) begin
                r_order[r_cnt] <= w_default;
                r_cnt          <= r_cnt + 1'b1;
                if (r_cnt == c_set_w'(SETS - 1)) r_ready <= 1'b1;
            end else begin
                if (w_touch_en) r_order[touch_set] <= w_touch_new;
                if (w_inval_en && !w_same) r_order[inval_set] <= w_inval_new;
            end
        end
    end

    // Reported from stored state only; a same-cycle update shows next cycle.
    assign ready  = r_ready;
    assign repair = r_repair;
    assign victim = r_ready ? r_order[query_set][WAYS-1] : '0;
    assign mru    = r_ready ? r_order[query_set][0]      : c_way_w'(WAYS - 1);

endmodule
`default_nettype wire
